// File: rtl/buffer_read_ctrl.sv
// buffer_read_ctrl: read side of a circular buffer; fetches entries through a 1-cycle-latency memory onto a valid/ready port.
module buffer_read_ctrl #(
    parameter int BufferWidth = 2,
    parameter int DataWidth   = 8
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   clk_en,
    input  logic                   sclr,
    input  logic                   wr_en,
    output logic                   rd_en,
    output logic [BufferWidth-1:0] rd_addr,
    input  logic [DataWidth-1:0]   rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DataWidth-1:0]   out_data,
    output logic [BufferWidth:0]   count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow
);
    localparam logic [BufferWidth:0] Depth = {1'b1, {BufferWidth{1'b0}}};
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [BufferWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [BufferWidth:0]   count_q, count_d;
    logic [DataWidth-1:0]   out_data_q, out_data_d;
    logic                   overflow_q, overflow_d;
    logic                   issue;

    assign issue = clk_en & ~sclr & (count_q != '0) &
                   ((state_q == IDLE) | ((state_q == HOLD) & out_ready));

    assign rd_en     = issue;
    assign rd_addr   = rd_ptr_q;
    // Valid is decoded from the state so an async reset drops it immediately.
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == Depth);
    assign overflow  = overflow_q;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q;
        if (clk_en && sclr) begin
            state_d    = IDLE;
            rd_ptr_d   = '0;
            count_d    = '0;
            out_data_d = '0;
            overflow_d = 1'b0;
        end else if (clk_en) begin
            rd_ptr_d   = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_d    = (wr_en && !issue && !full) ? count_q + 1'b1 :
                         (issue && !wr_en)          ? count_q - 1'b1 : count_q;
            overflow_d = overflow_q | (wr_en & ~issue & full);
            state_d    = issue                          ? FETCH :
                         (state_q == FETCH)             ? HOLD  :
                         (state_q == HOLD && out_ready) ? IDLE  : state_q;
            out_data_d = (state_q == FETCH) ? rd_data : out_data_q;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_buffer_read_ctrl.sv
// tb_buffer_read_ctrl: scoreboard bench for buffer_read_ctrl with a behavioural synchronous buffer memory.
module tb_buffer_read_ctrl;
    localparam int BW = 2;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          aclr_n, clk_en, sclr, wr_en, out_ready;
    logic          rd_en, out_valid, empty, full, overflow;
    logic [BW-1:0] rd_addr;
    logic [DW-1:0] rd_data, out_data;
    logic [BW:0]   count;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sb [$];
    logic [BW-1:0] aq [$];
    int vec = 0;
    int errs = 0;
    int wp = 0;

    buffer_read_ctrl #(.BufferWidth(BW), .DataWidth(DW)) dut (
        .clk(clk), .aclr_n(aclr_n), .clk_en(clk_en), .sclr(sclr), .wr_en(wr_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [DW-1:0] d);
        mem[wp] = d;
        sb.push_back(d);
        aq.push_back(BW'(wp));
        wp = (wp + 1) % DEPTH;
        wr_en = 1'b1;
    endtask

    task automatic clear_sb;
        sb.delete();
        aq.delete();
        wp = 0;
    endtask

    task automatic test_reset;
        aclr_n = 1'b0; clk_en = 1'b1; sclr = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
        repeat (3) next;
        aclr_n = 1'b1;
        clear_sb();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec++;
            if ({out_valid, rd_en, count, empty, full, overflow, rd_addr} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
                errs++;
                $display("FAIL reset_idle cycle %0d: got v/rd/cnt/e/f/ovf/addr=%b want 0_0_000_1_0_0_00", i,
                         {out_valid, rd_en, count, empty, full, overflow, rd_addr});
            end
            next;
        end
    endtask

    task automatic test_single;
        logic [BW-1:0] a;
        logic [DW-1:0] d;
        out_ready = 1'b1;
        push_wr(8'hA5);
        @(negedge clk);
        vec++;
        if (rd_en !== 1'b0 || count !== 3'd0) begin
            errs++; $display("FAIL single_w: rd_en=%b count=%0d want 0/0", rd_en, count);
        end
        next;
        wr_en = 1'b0;
        @(negedge clk);
        a = aq.pop_front();
        vec++;
        if ({rd_en, rd_addr, count} !== {1'b1, a, 3'd1}) begin
            errs++; $display("FAIL single_issue: rd_en=%b addr=%0d count=%0d want 1/%0d/1", rd_en, rd_addr, count, a);
        end
        next;
        @(negedge clk);
        vec++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL single_fetch: out_valid=%b want 0", out_valid);
        end
        next;
        @(negedge clk);
        d = sb.pop_front();
        vec++;
        if (out_valid !== 1'b1 || out_data !== d) begin
            errs++; $display("FAIL single_out: valid=%b data=%h want 1/%h", out_valid, out_data, d);
        end
        next;
        @(negedge clk);
        vec++;
        if ({out_valid, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
            errs++; $display("FAIL single_done: valid=%b count=%0d empty=%b want 0/0/1", out_valid, count, empty);
        end
        next;
    endtask

    task automatic test_backpressure_wrap;
        int n_wr = 0;
        int n_rd = 0;
        logic stalled = 1'b0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] d;
        logic [BW-1:0] a;
        sclr = 1'b1;
        next;
        sclr = 1'b0;
        clear_sb();
        for (int c = 0; c < 60 && n_rd < 6; c++) begin
            out_ready = !(c >= 4 && c < 9);
            wr_en = 1'b0;
            if (n_wr < 6 && c % 3 == 0) begin
                push_wr(DW'(8'h10 + n_wr));
                n_wr++;
            end
            @(negedge clk);
            if (stalled) begin
                vec++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errs++; $display("FAIL stall_stable c%0d: valid=%b data=%h want 1/%h", c, out_valid, out_data, held);
                end
            end
            if (rd_en) begin
                vec++;
                if (aq.size() == 0) begin
                    errs++; $display("FAIL wrap_addr c%0d: unexpected rd_en addr=%0d", c, rd_addr);
                end else begin
                    a = aq.pop_front();
                    if (rd_addr !== a) begin
                        errs++; $display("FAIL wrap_addr c%0d: addr=%0d want %0d", c, rd_addr, a);
                    end
                end
            end
            if (out_valid && out_ready) begin
                vec++;
                d = sb.pop_front();
                if (out_data !== d) begin
                    errs++; $display("FAIL wrap_data c%0d: data=%h want %h", c, out_data, d);
                end
                n_rd++;
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            next;
        end
        wr_en = 1'b0;
        vec++;
        if (n_rd != 6 || aq.size() != 0) begin
            errs++; $display("FAIL wrap_count: delivered=%0d want 6, addrs left=%0d want 0", n_rd, aq.size());
        end
    endtask

    task automatic test_full;
        sclr = 1'b1;
        next;
        sclr = 1'b0;
        clear_sb();
        out_ready = 1'b0;
        repeat (4) begin
            push_wr(DW'(8'h40 + wp));
            next;
        end
        wr_en = 1'b0;
        @(negedge clk);
        vec++;
        if ({count, full, out_valid} !== {3'd3, 1'b0, 1'b1} || out_data !== sb[0]) begin
            errs++; $display("FAIL full_park: count=%0d full=%b valid=%b data=%h want 3/0/1/%h", count, full, out_valid, out_data, sb[0]);
        end
        next;
        push_wr(8'h44);
        next;
        wr_en = 1'b1;
        @(negedge clk);
        vec++;
        if ({count, full, overflow} !== {3'd4, 1'b1, 1'b0}) begin
            errs++; $display("FAIL full_reach: count=%0d full=%b ovf=%b want 4/1/0", count, full, overflow);
        end
        next;
        wr_en = 1'b0;
        @(negedge clk);
        vec++;
        if ({count, full, overflow, out_valid} !== {3'd4, 1'b1, 1'b1, 1'b1} || out_data !== sb[0]) begin
            errs++; $display("FAIL overflow: count=%0d full=%b ovf=%b valid=%b data=%h want 4/1/1/1/%h",
                             count, full, overflow, out_valid, out_data, sb[0]);
        end
        next;
        sclr = 1'b1; wr_en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        vec++;
        if (rd_en !== 1'b0) begin
            errs++; $display("FAIL sclr_issue: rd_en=%b want 0", rd_en);
        end
        next;
        sclr = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        vec++;
        if ({count, overflow, out_valid, empty, rd_addr, out_data} !== {3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00}) begin
            errs++; $display("FAIL sclr_clear: count=%0d ovf=%b valid=%b empty=%b addr=%0d data=%h want 0/0/0/1/0/00",
                             count, overflow, out_valid, empty, rd_addr, out_data);
        end
        next;
        clear_sb();
    endtask

    task automatic test_clk_en;
        logic [BW-1:0] a;
        logic [DW-1:0] d;
        out_ready = 1'b1;
        push_wr(8'h5C);
        next;
        wr_en = 1'b0;
        @(negedge clk);
        a = aq.pop_front();
        vec++;
        if ({rd_en, rd_addr} !== {1'b1, a}) begin
            errs++; $display("FAIL clken_issue: rd_en=%b addr=%0d want 1/%0d", rd_en, rd_addr, a);
        end
        next;
        clk_en = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++;
            if ({out_valid, count, rd_addr, rd_en} !== {1'b0, 3'd0, 2'd1, 1'b0}) begin
                errs++; $display("FAIL clken_freeze %0d: valid=%b count=%0d addr=%0d rd_en=%b want 0/0/1/0",
                                 i, out_valid, count, rd_addr, rd_en);
            end
            next;
        end
        clk_en = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        vec++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL clken_resume: valid=%b want 0", out_valid);
        end
        next;
        @(negedge clk);
        d = sb.pop_front();
        vec++;
        if (out_valid !== 1'b1 || out_data !== d) begin
            errs++; $display("FAIL clken_out: valid=%b data=%h want 1/%h", out_valid, out_data, d);
        end
        next;
        @(negedge clk);
        vec++;
        if ({out_valid, count} !== {1'b0, 3'd0}) begin
            errs++; $display("FAIL clken_done: valid=%b count=%0d want 0/0", out_valid, count);
        end
        next;
    endtask

    task automatic test_async_reset;
        logic seen = 1'b0;
        out_ready = 1'b0;
        push_wr(8'h77);
        next;
        push_wr(8'h78);
        next;
        wr_en = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else next;
        end
        vec++;
        if (!seen || count !== 3'd1 || out_data !== sb[0]) begin
            errs++; $display("FAIL arst_setup: seen=%b count=%0d data=%h want 1/1/%h", seen, count, out_data, sb[0]);
        end
        aclr_n = 1'b0;
        #1;
        vec++;
        if ({out_valid, count, empty, rd_addr, overflow, rd_en, out_data} !== {1'b0, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00}) begin
            errs++; $display("FAIL arst_async: valid=%b count=%0d empty=%b addr=%0d ovf=%b rd_en=%b data=%h want 0/0/1/0/0/0/00",
                             out_valid, count, empty, rd_addr, overflow, rd_en, out_data);
        end
        next;
        aclr_n = 1'b1;
        clear_sb();
    endtask

    task automatic test_back_to_back;
        int last = -1;
        int n = 0;
        logic [BW-1:0] a;
        logic [DW-1:0] d;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && n < 4; c++) begin
            wr_en = 1'b0;
            if (c < 4) push_wr(DW'(8'hC0 + c));
            @(negedge clk);
            if (rd_en && aq.size() > 0) begin
                a = aq.pop_front();
                vec++;
                if (rd_addr !== a) begin
                    errs++; $display("FAIL b2b_addr c%0d: addr=%0d want %0d", c, rd_addr, a);
                end
            end
            if (out_valid && out_ready) begin
                d = sb.pop_front();
                vec++;
                if (out_data !== d) begin
                    errs++; $display("FAIL b2b_data c%0d: data=%h want %h", c, out_data, d);
                end
                if (last >= 0) begin
                    vec++;
                    if (c - last != 2) begin
                        errs++; $display("FAIL b2b_gap c%0d: gap=%0d want 2", c, c - last);
                    end
                end
                last = c;
                n++;
            end
            next;
        end
        wr_en = 1'b0;
        vec++;
        if (n != 4) begin
            errs++; $display("FAIL b2b_count: delivered=%0d want 4", n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure_wrap();
        test_full();
        test_clk_en();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
